// File: rtl/cmd_seq_pkg.sv
// cmd_seq_pkg: shared types and constants for the host-side command sequencer.
//   seq_state_t  - sequencer FSM states
//   ACK_DEFAULT  - response byte meaning success
//   OP_*         - opcode field (bits [15:12]) values and helper
package cmd_seq_pkg;

  localparam int unsigned CMD_W  = 16;
  localparam int unsigned RESP_W = 8;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND      = 3'd1,
    WAIT_SNT  = 3'd2,
    WAIT_RESP = 3'd3,
    ERR       = 3'd4
  } seq_state_t;

  localparam logic [RESP_W-1:0] ACK_DEFAULT = 8'hA5;

  // Opcode field of a command word
  localparam int unsigned OP_MSB  = 15;
  localparam int unsigned OP_LSB  = 12;
  localparam logic [3:0]  OP_CAL  = 4'h2;
  localparam logic [3:0]  OP_MOVE = 4'h4;

  function automatic logic [3:0] cmd_opcode(input logic [CMD_W-1:0] c);
    return c[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/cmd_seq_fifo.sv
// cmd_fifo: synchronous command FIFO, DEPTH entries (power of two) of CMD_W bits.
//   clk, rst    - clock, async active-high reset (pointers/count cleared)
//   flush       - discard all entries
//   push, wdata - write request and data
//   pop         - remove head entry
//   rdata       - current head entry (valid when !empty)
//   full, empty - occupancy status, decoded from the count register
//   drop        - push rejected this cycle because the FIFO was full
module cmd_fifo
  import cmd_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [CMD_W-1:0] wdata,
  input  logic             pop,
  output logic [CMD_W-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             drop
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [CMD_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // A pop in the same cycle frees the slot a push into a full FIFO needs
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  // Pointer and occupancy tracking; pointers wrap naturally (DEPTH = 2**AW)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  // Storage array, no reset needed: contents are only read behind count
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/cmd_seq.sv
// cmd_seq: host-side command sequencer. Queues 16-bit commands and issues
// them one at a time over the RemoteComm handshake, waiting for a response
// byte after each; flags NAKs, timeouts and FIFO overflow.
//   clk, rst            - clock, async active-high reset
//   wr_cmd, wr_data     - push a command word
//   abort               - flush queue, clear errors, return to IDLE
//   clr_err             - leave ERR and retry the head command
//   snd_cmd, cmd        - launch pulse and command word to RemoteComm
//   cmd_snt             - RemoteComm finished shifting the command
//   resp_rdy, resp      - response strobe and byte
//   full, empty         - queue status
//   busy                - sequencer not in IDLE
//   err_nak, err_timeout, ovfl - sticky error flags
//   done_cnt            - number of ACKed commands (wraps)
module cmd_seq
  import cmd_seq_pkg::*;
#(
  parameter int unsigned       DEPTH   = 8,
  parameter int unsigned       TIMEOUT = 1_000_000,
  parameter logic [RESP_W-1:0] ACK     = ACK_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_cmd,
  input  logic [CMD_W-1:0]  wr_data,
  input  logic              abort,
  input  logic              clr_err,
  output logic              snd_cmd,
  output logic [CMD_W-1:0]  cmd,
  input  logic              cmd_snt,
  input  logic              resp_rdy,
  input  logic [RESP_W-1:0] resp,
  output logic              full,
  output logic              empty,
  output logic              busy,
  output logic              err_nak,
  output logic              err_timeout,
  output logic              ovfl,
  output logic [CNT_W-1:0]  done_cnt
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  seq_state_t       state;
  seq_state_t       state_nxt;
  logic [TW-1:0]    tmr;
  logic             tmr_hit;
  logic [CMD_W-1:0] head;
  logic             drop_c;
  logic             ack_c;
  logic             nak_c;
  logic             tmo_c;
  logic             clr_c;
  logic             load_c;

  cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (abort),
    .push  (wr_cmd && !abort),
    .wdata (wr_data),
    .pop   (ack_c),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .drop  (drop_c)
  );

  assign snd_cmd = (state == SEND);
  assign busy    = (state != IDLE);
  assign tmr_hit = (tmr == TW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and per-cycle strobes; abort overrides everything
  always_comb begin
    state_nxt = state;
    ack_c     = 1'b0;
    nak_c     = 1'b0;
    tmo_c     = 1'b0;
    clr_c     = 1'b0;
    load_c    = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (!empty) begin
            state_nxt = SEND;
            load_c    = 1'b1;
          end
        end
        SEND: state_nxt = WAIT_SNT;
        // resp_rdy in WAIT_SNT doubles as cmd_snt; it also beats expiry
        WAIT_SNT, WAIT_RESP: begin
          if (resp_rdy) begin
            if (resp == ACK) begin
              ack_c     = 1'b1;
              state_nxt = IDLE;
            end else begin
              nak_c     = 1'b1;
              state_nxt = ERR;
            end
          end else if (tmr_hit) begin
            tmo_c     = 1'b1;
            state_nxt = ERR;
          end else if (state == WAIT_SNT && cmd_snt) begin
            state_nxt = WAIT_RESP;
          end
        end
        ERR: begin
          if (clr_err) begin
            clr_c     = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Response timer: zeroed while launching, runs while awaiting the robot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr <= '0;
    end else if (state == SEND) begin
      tmr <= '0;
    end else if (state == WAIT_SNT || state == WAIT_RESP) begin
      tmr <= tmr + TW'(1);
    end
  end

  // Command word latched on entry to SEND and held until the next launch
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         cmd <= '0;
    else if (load_c) cmd <= head;
  end

  // ACK counter, untouched by abort
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        done_cnt <= '0;
    else if (ack_c) done_cnt <= done_cnt + CNT_W'(1);
  end

  // Sticky error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_nak     <= 1'b0;
      err_timeout <= 1'b0;
      ovfl        <= 1'b0;
    end else if (abort) begin
      err_nak     <= 1'b0;
      err_timeout <= 1'b0;
      ovfl        <= 1'b0;
    end else begin
      if (clr_c) begin
        err_nak     <= 1'b0;
        err_timeout <= 1'b0;
      end
      if (nak_c)  err_nak     <= 1'b1;
      if (tmo_c)  err_timeout <= 1'b1;
      if (drop_c) ovfl        <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cmd_seq.sv
// tb_cmd_seq: self-checking bench for cmd_seq. A per-cycle vector table covers
// launch/ACK/NAK/retry/abort timing; hand-written sequences cover long
// responses, back-to-back spacing, timeout, overflow, abort and async reset.
module tb_cmd_seq;
  import cmd_seq_pkg::*;

  localparam logic [15:0] CAL = {OP_CAL, 12'h000};
  localparam logic [15:0] MV1 = {OP_MOVE, 12'h001};
  localparam logic [7:0]  AK  = 8'hA5;
  localparam logic [7:0]  NK  = 8'h5A;

  logic        clk, rst, wr_cmd, abort, clr_err, cmd_snt, resp_rdy;
  logic [15:0] wr_data;
  logic [7:0]  resp;
  logic        snd_cmd, full, empty, busy, err_nak, err_timeout, ovfl;
  logic [15:0] cmd;
  logic [7:0]  done_cnt;
  logic        t_snd, t_full, t_empty, t_busy, t_nak, t_tmo, t_ovfl;
  logic [15:0] t_cmd;
  logic [7:0]  t_done;

  cmd_seq #(.DEPTH(8), .TIMEOUT(1000), .ACK(AK)) u_dut (
    .clk(clk), .rst(rst), .wr_cmd(wr_cmd), .wr_data(wr_data), .abort(abort),
    .clr_err(clr_err), .snd_cmd(snd_cmd), .cmd(cmd), .cmd_snt(cmd_snt),
    .resp_rdy(resp_rdy), .resp(resp), .full(full), .empty(empty), .busy(busy),
    .err_nak(err_nak), .err_timeout(err_timeout), .ovfl(ovfl), .done_cnt(done_cnt)
  );

  cmd_seq #(.DEPTH(8), .TIMEOUT(100), .ACK(AK)) u_tmo (
    .clk(clk), .rst(rst), .wr_cmd(wr_cmd), .wr_data(wr_data), .abort(abort),
    .clr_err(clr_err), .snd_cmd(t_snd), .cmd(t_cmd), .cmd_snt(cmd_snt),
    .resp_rdy(resp_rdy), .resp(resp), .full(t_full), .empty(t_empty), .busy(t_busy),
    .err_nak(t_nak), .err_timeout(t_tmo), .ovfl(t_ovfl), .done_cnt(t_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  logic [15:0] launch_log[$];
  int          launch_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Launch monitor: every SEND cycle is logged with its command and cycle
  always @(negedge clk) begin
    if (!rst && snd_cmd) begin
      launch_log.push_back(cmd);
      launch_cyc.push_back(cyc);
    end
  end

  typedef struct packed {
    logic        wr;
    logic [15:0] wd;
    logic        snt;
    logic        rr;
    logic [7:0]  rsp;
    logic        ab;
    logic        ce;
    logic        e_snd;
    logic [15:0] e_cmd;
    logic        e_busy;
    logic        e_empty;
    logic        e_nak;
    logic [7:0]  e_done;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic wr, input logic [15:0] wd, input logic snt,
                              input logic rr, input logic [7:0] rsp, input logic ab,
                              input logic ce, input logic e_snd, input logic [15:0] e_cmd,
                              input logic e_busy, input logic e_empty, input logic e_nak,
                              input logic [7:0] e_done);
    vec_t v;
    v.wr = wr; v.wd = wd; v.snt = snt; v.rr = rr; v.rsp = rsp; v.ab = ab; v.ce = ce;
    v.e_snd = e_snd; v.e_cmd = e_cmd; v.e_busy = e_busy; v.e_empty = e_empty;
    v.e_nak = e_nak; v.e_done = e_done;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_cmd = 1'b0; wr_data = '0; abort = 1'b0; clr_err = 1'b0;
    cmd_snt = 1'b0; resp_rdy = 1'b0; resp = '0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    launch_log.delete();
    launch_cyc.delete();
  endtask

  task automatic push(input logic [15:0] d);
    wr_cmd = 1'b1; wr_data = d;
    tick();
    wr_cmd = 1'b0;
  endtask

  task automatic check_rst(input string tag);
    check(tag, 32'({snd_cmd, cmd, busy, full, empty, err_nak, err_timeout, ovfl, done_cnt}),
          32'({1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0}));
  endtask

  // Waits (bounded) until launch idx has been logged; returns past its SEND cycle
  task automatic wait_launch(input int idx);
    int n = 0;
    while (launch_log.size() <= idx && n < 3000) begin
      tick();
      n++;
    end
    check($sformatf("launch%0d_seen", idx), 32'(launch_log.size() > idx), 32'(1));
    if (snd_cmd) tick();
  endtask

  task automatic serve(input int idx, input int dly, input logic [7:0] r, output int rc);
    wait_launch(idx);
    repeat (dly) tick();
    resp_rdy = 1'b1; resp = r;
    tick();
    resp_rdy = 1'b0;
    rc = cyc;
  endtask

  initial begin
    int rc0, rc1, rc2, sz;

    // Reset state
    do_reset();
    check_rst("reset_vals");

    // Per-cycle vectors: launch, ACK, NAK, retry, clr_err/resp in IDLE, abort
    //              wr  wd     snt rr  rsp ab ce | snd cmd   busy empty nak done
    vecs[0]  = mk(1, CAL,   0, 0, 0,  0, 0,   0, 16'h0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0,     0, 0, 0,  0, 0,   1, CAL,   1, 0, 0, 0);
    vecs[2]  = mk(0, 0,     0, 0, 0,  0, 0,   0, CAL,   1, 0, 0, 0);
    vecs[3]  = mk(0, 0,     1, 0, 0,  0, 0,   0, CAL,   1, 0, 0, 0);
    vecs[4]  = mk(0, 0,     0, 1, AK, 0, 0,   0, CAL,   0, 1, 0, 1);
    vecs[5]  = mk(1, MV1,   0, 0, 0,  0, 0,   0, CAL,   0, 0, 0, 1);
    vecs[6]  = mk(0, 0,     0, 0, 0,  0, 0,   1, MV1,   1, 0, 0, 1);
    vecs[7]  = mk(0, 0,     0, 0, 0,  0, 0,   0, MV1,   1, 0, 0, 1);
    vecs[8]  = mk(0, 0,     0, 1, NK, 0, 0,   0, MV1,   1, 0, 1, 1);
    vecs[9]  = mk(0, 0,     0, 0, 0,  0, 0,   0, MV1,   1, 0, 1, 1);
    vecs[10] = mk(0, 0,     0, 0, 0,  0, 1,   0, MV1,   0, 0, 0, 1);
    vecs[11] = mk(0, 0,     0, 0, 0,  0, 0,   1, MV1,   1, 0, 0, 1);
    vecs[12] = mk(0, 0,     0, 0, 0,  0, 0,   0, MV1,   1, 0, 0, 1);
    vecs[13] = mk(0, 0,     0, 1, AK, 0, 0,   0, MV1,   0, 1, 0, 2);
    vecs[14] = mk(0, 0,     0, 1, AK, 0, 1,   0, MV1,   0, 1, 0, 2);
    vecs[15] = mk(1, CAL,   0, 0, 0,  0, 0,   0, MV1,   0, 0, 0, 2);
    vecs[16] = mk(0, 0,     0, 0, 0,  0, 0,   1, CAL,   1, 0, 0, 2);
    vecs[17] = mk(0, 0,     0, 0, 0,  1, 0,   0, CAL,   0, 1, 0, 2);
    vecs[18] = mk(0, 0,     0, 1, AK, 0, 0,   0, CAL,   0, 1, 0, 2);
    for (int i = 0; i < NV; i++) begin
      wr_cmd = vecs[i].wr; wr_data = vecs[i].wd; cmd_snt = vecs[i].snt;
      resp_rdy = vecs[i].rr; resp = vecs[i].rsp; abort = vecs[i].ab; clr_err = vecs[i].ce;
      tick();
      check($sformatf("vec%0d", i),
            32'({snd_cmd, cmd, busy, empty, err_nak, done_cnt}),
            32'({vecs[i].e_snd, vecs[i].e_cmd, vecs[i].e_busy, vecs[i].e_empty,
                 vecs[i].e_nak, vecs[i].e_done}));
    end
    wr_cmd = 0; cmd_snt = 0; resp_rdy = 0; abort = 0; clr_err = 0;

    // Single calibrate command, response ~500 cycles after launch
    do_reset();
    push(CAL);
    wait_launch(0);
    check("single_cmd", 32'({cmd_opcode(cmd), cmd}), 32'({OP_CAL, CAL}));
    repeat (20) tick();
    cmd_snt = 1'b1; tick(); cmd_snt = 1'b0;
    repeat (477) tick();
    check("single_busy_wait", 32'({busy, done_cnt}), 32'({1'b1, 8'd0}));
    resp_rdy = 1'b1; resp = AK; tick(); resp_rdy = 1'b0;
    check("single_done", 32'({done_cnt, busy, empty}), 32'({8'd1, 1'b0, 1'b1}));
    repeat (5) tick();
    check("single_one_launch", 32'(launch_log.size()), 32'(1));

    // Back-to-back: three launches, each one idle cycle after the previous ACK
    do_reset();
    push(CAL); push(MV1); push(MV1);
    serve(0, 5, AK, rc0);
    serve(1, 5, AK, rc1);
    serve(2, 5, AK, rc2);
    tick();
    check("b2b_count", 32'(launch_log.size()), 32'(3));
    check("b2b_order", 32'({launch_log[0], launch_log[1]}), 32'({CAL, MV1}));
    check("b2b_third", 32'(launch_log[2]), 32'(MV1));
    check("b2b_gap1", 32'(launch_cyc[1]), 32'(rc0 + 1));
    check("b2b_gap2", 32'(launch_cyc[2]), 32'(rc1 + 1));
    check("b2b_done", 32'({done_cnt, busy, empty}), 32'({8'd3, 1'b0, 1'b1}));

    // Timeout on the TIMEOUT=100 instance: 100 waiting cycles after the launch
    do_reset();
    push(CAL);
    tick();
    check("tmo_launch", 32'({t_snd, t_cmd}), 32'({1'b1, CAL}));
    repeat (100) tick();
    check("tmo_not_yet", 32'({t_tmo, t_busy}), 32'({1'b0, 1'b1}));
    tick();
    check("tmo_set", 32'({t_tmo, t_busy}), 32'({1'b1, 1'b1}));
    check("tmo_dut_clear", 32'(err_timeout), 32'(0));
    repeat (5) tick();
    check("tmo_hold", 32'({t_tmo, t_snd, t_busy}), 32'({1'b1, 1'b0, 1'b1}));
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    check("tmo_clr", 32'({t_tmo, t_busy}), 32'({1'b0, 1'b0}));
    tick();
    check("tmo_retry", 32'({t_snd, t_cmd}), 32'({1'b1, CAL}));

    // Overflow: 10 pushes into 8 entries with the responder stalled
    do_reset();
    for (int i = 0; i < 10; i++) begin
      push(16'(16'h4000 + i));
      if (i == 7) check("ovf_full8", 32'({full, ovfl}), 32'({1'b1, 1'b0}));
    end
    check("ovf_flag", 32'({full, ovfl}), 32'({1'b1, 1'b1}));
    for (int i = 0; i < 8; i++) serve(i, 2, AK, rc0);
    repeat (20) tick();
    check("ovf_launches", 32'(launch_log.size()), 32'(8));
    for (int i = 0; i < 8; i++) begin
      if (launch_log.size() > i)
        check($sformatf("ovf_cmd%0d", i), 32'(launch_log[i]), 32'(16'h4000 + i));
    end
    check("ovf_done", 32'({done_cnt, empty, ovfl}), 32'({8'd8, 1'b1, 1'b1}));
    abort = 1'b1; tick(); abort = 1'b0;
    check("ovf_abort_clr", 32'(ovfl), 32'(0));

    // Push into a full FIFO in the same cycle as the ACK pop is accepted
    do_reset();
    for (int i = 0; i < 8; i++) push(16'(16'h4300 + i));
    wait_launch(0);
    tick();
    resp_rdy = 1'b1; resp = AK; wr_cmd = 1'b1; wr_data = 16'h5555;
    tick();
    resp_rdy = 1'b0; wr_cmd = 1'b0;
    check("pushpop_full", 32'({full, ovfl, done_cnt}), 32'({1'b1, 1'b0, 8'd1}));

    // Abort mid-WAIT_RESP with 3 commands queued behind the in-flight one
    do_reset();
    for (int i = 0; i < 5; i++) push(16'(16'h4100 + i));
    serve(0, 3, AK, rc0);
    wait_launch(1);
    cmd_snt = 1'b1; tick(); cmd_snt = 1'b0;
    check("abt_pre", 32'({busy, empty}), 32'({1'b1, 1'b0}));
    abort = 1'b1; tick(); abort = 1'b0;
    check("abt_state", 32'({empty, busy, full, err_nak, err_timeout, ovfl}), 32'(6'b100000));
    check("abt_keep", 32'({cmd, done_cnt}), 32'({16'h4101, 8'd1}));
    resp_rdy = 1'b1; resp = AK; tick(); resp_rdy = 1'b0;
    check("abt_late_resp", 32'({done_cnt, busy}), 32'({8'd1, 1'b0}));
    repeat (10) tick();
    check("abt_no_launch", 32'(launch_log.size()), 32'(2));

    // Asynchronous reset mid-transaction with errors and a full queue
    do_reset();
    push(16'h4200); push(16'h4201);
    serve(0, 3, AK, rc0);
    wait_launch(1);
    tick();
    resp_rdy = 1'b1; resp = NK; tick(); resp_rdy = 1'b0;
    check("rst_pre_nak", 32'({err_nak, busy, done_cnt, cmd}), 32'({1'b1, 1'b1, 8'd1, 16'h4201}));
    for (int i = 0; i < 8; i++) push(16'(16'h4210 + i));
    check("rst_pre_full", 32'({full, ovfl}), 32'({1'b1, 1'b1}));
    sz = launch_log.size();
    #2 rst = 1'b1;
    #1 check_rst("rst_async");
    tick();
    rst = 1'b0;
    repeat (5) tick();
    check("rst_discard", 32'({empty, busy, snd_cmd, 16'(launch_log.size())}),
          32'({1'b1, 1'b0, 1'b0, 16'(sz)}));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
